cpu_datapath: RTL and testbench
===============================

# cpu_datapath

Register-and-ALU datapath for the 8-bit accumulator CPU, directly downstream of `FSMController`. It consumes the controller's strobes (`load_ac`, `mem_rd`, `mem_wr`, `inc_pc`, `load_pc`, `load_ir`, `halt`) and its `state`. It holds the program counter, instruction register and accumulator, drives the single-port memory interface, and feeds `opcode` and `zero` back to the controller.

## Interface
- `DATA_WIDTH`, 8: accumulator, memory data and instruction width.
- `ADDR_WIDTH`, 5: PC and operand address width. Requires DATA_WIDTH = ADDR_WIDTH + 3.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `state`  in  state_t: controller phase; selects the address source.
- `load_ac`, `mem_rd`, `mem_wr`, `inc_pc`, `load_pc`, `load_ir`, `halt`  in  1 each: controller strobes.
- `mem_rdata`  in  DATA_WIDTH: memory read data; combinational from `mem_addr`.
- `mem_addr`  out  ADDR_WIDTH: memory address.
- `mem_wdata`  out  DATA_WIDTH: write data; always equals `ac`.
- `mem_we`  out  1: write enable; equals `mem_wr`, gated to 0 while `halted`.
- `mem_re`  out  1: read enable; equals `mem_rd`.
- `opcode`  out  opcode_t: `ir[DATA_WIDTH-1 -: 3]`.
- `zero`  out  1: `ac == 0`, combinational.
- `pc`  out  ADDR_WIDTH: current PC, for debug.
- `ac`  out  DATA_WIDTH: accumulator.
- `halted`  out  1: sticky halt flag.

## Operation
**Reset** (`rst`=1 at an edge): pc=0, ir=0 (opcode HLT), ac=0, halted=0. After reset, `zero`=1 and `mem_addr`=0.

**Address mux**
- `mem_addr` = `pc` when `state` is INST_ADDR, INST_FETCH, INST_LOAD or IDLE.
- `mem_addr` = `ir[ADDR_WIDTH-1:0]` when `state` is OP_ADDR, OP_FETCH, ALU_OP or STORE.

**IR**
- Loads `mem_rdata` when `load_ir`=1.
- `load_ir` with `mem_rd`=0 still loads. This is the controller's error, not checked here.

**PC**
- `load_pc`=1: pc ← `ir[ADDR_WIDTH-1:0]`. `load_pc` has priority over `inc_pc` when both are asserted (JMP case).
- `inc_pc`=1 alone: pc ← pc+1, modulo 2^ADDR_WIDTH. 31 wraps to 0.

**AC**
- When `load_ac`=1, ac ← ALU result, selected by `opcode`:
  - ADD: `ac + mem_rdata`, truncated to DATA_WIDTH; carry discarded.
  - AND: `ac & mem_rdata`.
  - XOR: `ac ^ mem_rdata`.
  - LDA: `mem_rdata`.
  - HLT, SKZ, STO, JMP: `ac` (no change).
- ALU is purely combinational.

**Halt**
- `halt`=1 at an edge sets `halted`=1.
- While `halted`=1: pc, ir and ac hold regardless of strobes, and `mem_we` is forced to 0.
- Only `rst` clears `halted`.

**Simultaneous events**
- `rst` overrides everything.
- `halt` and `load_ac` at the same edge: ac still updates on that edge; the freeze applies from the next edge.
- `load_ir` and `load_ac` at the same edge: the ALU uses the old `ir` opcode.

## Timing
- Every register updates exactly one edge after its strobe is sampled high. No internal pipeline.
- `opcode` and `zero` are valid in the cycle after the IR/AC load, ahead of the controller's next decision edge.
- Read path: `mem_addr` and `mem_rdata` settle within the cycle; the capture edge is the one at which `load_ir`/`load_ac` is high.
- Write path: `mem_we`, `mem_addr` and `mem_wdata` are all valid in the same cycle; memory writes at the rising edge.
- Reset mid-instruction: on the next edge all registers take reset values, regardless of `state`.

## Structure
- Package `typedefs` already holds `opcode_t` (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP = 0..7) and `state_t`.
- Add to `typedefs`: `OPC_WIDTH` = 3, plus a function `is_op_phase(state_t)` used by the address mux.
- One sub-module, `alu`: inputs `opcode`, `accum`, `data`; output `result`. Combinational, parameterised by DATA_WIDTH.
- PC, IR, AC and `halted` stay in `cpu_datapath`.

## Test plan
- **Reset:** assert `rst` for one edge mid-run with pc=0x0A, ac=0x55 → pc=0, ac=0, `zero`=1, `opcode`=HLT, `halted`=0 after that edge.
- **Fetch/ALU:**
  - `state`=INST_LOAD, `mem_rdata`=0x45 (ADD, addr 5), `load_ir`=1 → `opcode`=ADD, `mem_addr`=5 once `state`=OP_ADDR.
  - With ac=0xF0, `mem_rdata`=0x20, `load_ac`=1 → ac=0x10 (carry dropped), `zero`=0.
- **XOR to zero:** ac=0x3C, opcode XOR, `mem_rdata`=0x3C, `load_ac`=1 → ac=0, `zero`=1 the next cycle.
- **JMP priority and wrap:**
  - ir=0xFA (JMP, addr 26), `load_pc`=1 and `inc_pc`=1 together → pc=26.
  - pc=31, `inc_pc`=1 → pc=0.
- **Store:** ac=0x7E, opcode STO, `state`=STORE, `mem_wr`=1 → `mem_we`=1, `mem_addr`=ir operand, `mem_wdata`=0x7E in the same cycle.
- **Halt:**
  - `halt`=1 for one edge → `halted`=1.
  - Subsequent `inc_pc`/`load_ac`/`mem_wr` pulses leave pc and ac unchanged and keep `mem_we`=0.
  - `rst` clears `halted`.

Source files
------------

// File: rtl/cpu_datapath_pkg.sv
// ---------------------------------------------------------------------------
// typedefs
//   Shared types for the 8-bit accumulator CPU: instruction opcodes,
//   controller phases, and the helper that tells the datapath which phases
//   address memory through the instruction operand rather than the PC.
// ---------------------------------------------------------------------------
package typedefs;

    localparam int OPC_WIDTH = 3;

    typedef enum logic [OPC_WIDTH-1:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } state_t;

    // True in the phases where memory is addressed by the IR operand field.
    function automatic logic is_op_phase(input state_t st);
        logic op_phase;
        case (st)
            OP_ADDR, OP_FETCH, ALU_OP, STORE: op_phase = 1'b1;
            default:                          op_phase = 1'b0;
        endcase
        return op_phase;
    endfunction

endpackage : typedefs

// File: rtl/cpu_datapath_alu.sv
// ---------------------------------------------------------------------------
// alu
//   Purely combinational ALU for the accumulator CPU.
//
//   opcode  in   opcode_t          instruction opcode (from IR)
//   accum   in   DATA_WIDTH        current accumulator
//   data    in   DATA_WIDTH        memory operand
//   result  out  DATA_WIDTH        next accumulator value
//
//   Opcodes that do not touch the accumulator pass it through unchanged so
//   a stray load_ac during them is harmless.
// ---------------------------------------------------------------------------
module alu
    import typedefs::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  opcode_t               opcode,
    input  logic [DATA_WIDTH-1:0] accum,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        result = accum;
        case (opcode)
            ADD:     result = accum + data;   // carry discarded by width
            AND:     result = accum & data;
            XOR:     result = accum ^ data;
            LDA:     result = data;
            default: result = accum;          // HLT, SKZ, STO, JMP
        endcase
    end

endmodule : alu

// File: rtl/cpu_datapath.sv
// ---------------------------------------------------------------------------
// cpu_datapath
//   Register-and-ALU datapath of the 8-bit accumulator CPU. Holds PC, IR,
//   AC and the sticky halt flag, drives the single-port memory, and returns
//   opcode/zero to the controller.
//
//   clk        in   1           clock, rising edge
//   rst        in   1           synchronous active-high reset
//   state      in   state_t     controller phase, selects address source
//   load_ac    in   1           capture ALU result into AC
//   mem_rd     in   1           memory read strobe
//   mem_wr     in   1           memory write strobe
//   inc_pc     in   1           PC increment
//   load_pc    in   1           PC <- IR operand (wins over inc_pc)
//   load_ir    in   1           IR <- mem_rdata
//   halt       in   1           set sticky halted flag
//   mem_rdata  in   DATA_WIDTH  combinational read data
//   mem_addr   out  ADDR_WIDTH  memory address
//   mem_wdata  out  DATA_WIDTH  write data (always AC)
//   mem_we     out  1           write enable, blocked while halted
//   mem_re     out  1           read enable
//   opcode     out  opcode_t    IR opcode field
//   zero       out  1           AC == 0
//   pc         out  ADDR_WIDTH  program counter (debug)
//   ac         out  DATA_WIDTH  accumulator
//   halted     out  1           sticky halt flag
//
//   DATA_WIDTH must equal ADDR_WIDTH + OPC_WIDTH: the instruction word is
//   exactly opcode followed by operand address.
// ---------------------------------------------------------------------------
module cpu_datapath
    import typedefs::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  state_t                state,
    input  logic                  load_ac,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic                  inc_pc,
    input  logic                  load_pc,
    input  logic                  load_ir,
    input  logic                  halt,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    output opcode_t               opcode,
    output logic                  zero,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ac,
    output logic                  halted
);

    logic [DATA_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [ADDR_WIDTH-1:0] ir_operand;

    assign ir_operand = ir[ADDR_WIDTH-1:0];
    assign opcode     = opcode_t'(ir[DATA_WIDTH-1 -: OPC_WIDTH]);
    assign zero       = (ac == '0);

    assign mem_addr   = is_op_phase(state) ? ir_operand : pc;
    assign mem_wdata  = ac;
    assign mem_we     = mem_wr & ~halted;
    assign mem_re     = mem_rd;

    // ALU sees the IR as it stands before this edge, so a simultaneous
    // load_ir/load_ac executes the old instruction.
    alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .opcode (opcode),
        .accum  (ac),
        .data   (mem_rdata),
        .result (alu_result)
    );

    // The freeze keys off the registered halted flag, so strobes that
    // arrive together with halt still take effect on that same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= '0;
            ir     <= '0;
            ac     <= '0;
            halted <= 1'b0;
        end else begin
            if (halt) begin
                halted <= 1'b1;
            end
            if (!halted) begin
                if (load_ir) begin
                    ir <= mem_rdata;
                end
                if (load_pc) begin
                    pc <= ir_operand;
                end else if (inc_pc) begin
                    pc <= pc + ADDR_WIDTH'(1);
                end
                if (load_ac) begin
                    ac <= alu_result;
                end
            end
        end
    end

endmodule : cpu_datapath

// File: tb/tb_cpu_datapath.sv
module tb_cpu_datapath;
    import typedefs::*;

    logic       clk = 1'b0;
    logic       rst;
    state_t     state;
    logic       load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, halt;
    logic [7:0] mem_rdata;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we, mem_re;
    opcode_t    opcode;
    logic       zero;
    logic [4:0] pc;
    logic [7:0] ac;
    logic       halted;

    int checks = 0;
    int errors = 0;

    cpu_datapath #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .load_ac   (load_ac),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .inc_pc    (inc_pc),
        .load_pc   (load_pc),
        .load_ir   (load_ir),
        .halt      (halt),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .opcode    (opcode),
        .zero      (zero),
        .pc        (pc),
        .ac        (ac),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; state = IDLE;
        load_ac = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; inc_pc = 1'b0;
        load_pc = 1'b0; load_ir = 1'b0; halt = 1'b0; mem_rdata = 8'h00;
    endtask

    task automatic do_load_ir(input logic [7:0] word);
        idle_inputs(); state = INST_LOAD; mem_rd = 1'b1; load_ir = 1'b1; mem_rdata = word;
        step(); idle_inputs();
    endtask

    task automatic do_load_ac(input logic [7:0] data);
        idle_inputs(); state = ALU_OP; mem_rd = 1'b1; load_ac = 1'b1; mem_rdata = data;
        step(); idle_inputs();
    endtask

    task automatic do_load_pc();
        idle_inputs(); load_pc = 1'b1;
        step(); idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs(); rst = 1'b1; step(); idle_inputs();
        checks++; if (pc !== 5'd0) begin errors++; $display("FAIL por_pc got %h exp %h", pc, 5'd0); end
        checks++; if (ac !== 8'h00) begin errors++; $display("FAIL por_ac got %h exp %h", ac, 8'h00); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL por_zero got %b exp 1", zero); end
        checks++; if (opcode !== HLT) begin errors++; $display("FAIL por_opcode got %0d exp %0d", opcode, HLT); end
        checks++; if (mem_addr !== 5'd0) begin errors++; $display("FAIL por_mem_addr got %h exp 0", mem_addr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL por_halted got %b exp 0", halted); end
        // Bring to pc=0x0A, ac=0x55 then reset mid-run.
        do_load_ir(8'hA0);           // LDA
        do_load_ac(8'h55);
        do_load_ir(8'hEA);           // JMP 10
        do_load_pc();
        checks++; if (pc !== 5'h0A) begin errors++; $display("FAIL pre_rst_pc got %h exp 0a", pc); end
        checks++; if (ac !== 8'h55) begin errors++; $display("FAIL pre_rst_ac got %h exp 55", ac); end
        idle_inputs(); rst = 1'b1; state = ALU_OP; inc_pc = 1'b1; load_ac = 1'b1; mem_rdata = 8'h77;
        step(); idle_inputs();
        checks++; if (pc !== 5'd0) begin errors++; $display("FAIL rst_pc got %h exp 0", pc); end
        checks++; if (ac !== 8'h00) begin errors++; $display("FAIL rst_ac got %h exp 0", ac); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL rst_zero got %b exp 1", zero); end
        checks++; if (opcode !== HLT) begin errors++; $display("FAIL rst_opcode got %0d exp %0d", opcode, HLT); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", halted); end
    endtask

    task automatic test_fetch_alu();
        do_load_ir(8'hA0);           // LDA
        do_load_ac(8'hF0);
        checks++; if (ac !== 8'hF0) begin errors++; $display("FAIL lda_ac got %h exp f0", ac); end
        do_load_ir(8'h45);           // ADD 5
        checks++; if (opcode !== ADD) begin errors++; $display("FAIL fetch_opcode got %0d exp %0d", opcode, ADD); end
        state = INST_LOAD; #1;
        checks++; if (mem_addr !== 5'd0) begin errors++; $display("FAIL inst_addr got %h exp 0", mem_addr); end
        state = OP_ADDR; #1;
        checks++; if (mem_addr !== 5'd5) begin errors++; $display("FAIL op_addr got %h exp 5", mem_addr); end
        do_load_ac(8'h20);
        checks++; if (ac !== 8'h10) begin errors++; $display("FAIL add_carry got %h exp 10", ac); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add_zero got %b exp 0", zero); end
        do_load_ir(8'h63);           // AND 3
        do_load_ac(8'h1F);
        checks++; if (ac !== 8'h10) begin errors++; $display("FAIL and_ac got %h exp 10", ac); end
    endtask

    task automatic test_xor_zero();
        do_load_ir(8'hA0);
        do_load_ac(8'h3C);
        do_load_ir(8'h83);           // XOR 3
        do_load_ac(8'h3C);
        checks++; if (ac !== 8'h00) begin errors++; $display("FAIL xor_ac got %h exp 0", ac); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL xor_zero got %b exp 1", zero); end
    endtask

    task automatic test_ir_ac_same_edge();
        do_load_ir(8'hA0);
        do_load_ac(8'h10);
        do_load_ir(8'h45);           // ADD
        idle_inputs(); state = ALU_OP; load_ir = 1'b1; load_ac = 1'b1; mem_rdata = 8'hA3;
        step(); idle_inputs();
        checks++; if (ac !== 8'hB3) begin errors++; $display("FAIL same_edge_ac got %h exp b3", ac); end
        checks++; if (opcode !== LDA) begin errors++; $display("FAIL same_edge_opcode got %0d exp %0d", opcode, LDA); end
    endtask

    task automatic test_jmp_wrap();
        do_load_ir(8'hFA);           // JMP 26
        idle_inputs(); load_pc = 1'b1; inc_pc = 1'b1; step(); idle_inputs();
        checks++; if (pc !== 5'd26) begin errors++; $display("FAIL jmp_prio got %0d exp 26", pc); end
        inc_pc = 1'b1; step(); idle_inputs();
        checks++; if (pc !== 5'd27) begin errors++; $display("FAIL inc_pc got %0d exp 27", pc); end
        do_load_ir(8'hFF);           // JMP 31
        do_load_pc();
        checks++; if (pc !== 5'd31) begin errors++; $display("FAIL jmp31 got %0d exp 31", pc); end
        inc_pc = 1'b1; step(); idle_inputs();
        checks++; if (pc !== 5'd0) begin errors++; $display("FAIL pc_wrap got %0d exp 0", pc); end
    endtask

    task automatic test_store();
        do_load_ir(8'hA0);
        do_load_ac(8'h7E);
        do_load_ir(8'hC9);           // STO 9
        state = STORE; mem_wr = 1'b1; #1;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sto_we got %b exp 1", mem_we); end
        checks++; if (mem_addr !== 5'd9) begin errors++; $display("FAIL sto_addr got %h exp 9", mem_addr); end
        checks++; if (mem_wdata !== 8'h7E) begin errors++; $display("FAIL sto_wdata got %h exp 7e", mem_wdata); end
        checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL sto_re got %b exp 0", mem_re); end
        step(); idle_inputs();
        state = OP_FETCH; mem_rd = 1'b1; #1;
        checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL rd_re got %b exp 1", mem_re); end
        idle_inputs();
    endtask

    task automatic test_halt();
        do_load_ir(8'hE3);           // JMP 3
        do_load_pc();
        do_load_ir(8'hA0);           // LDA
        do_load_ac(8'h11);
        // halt together with load_ac: ac still updates on this edge
        idle_inputs(); state = ALU_OP; halt = 1'b1; load_ac = 1'b1; mem_rdata = 8'h22;
        step(); idle_inputs();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set got %b exp 1", halted); end
        checks++; if (ac !== 8'h22) begin errors++; $display("FAIL halt_same_edge_ac got %h exp 22", ac); end
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); state = STORE; inc_pc = 1'b1; load_ac = 1'b1; load_ir = 1'b1;
            mem_wr = 1'b1; mem_rdata = 8'h45 + 8'(i); #1;
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL halt_we got %b exp 0", mem_we); end
            step(); idle_inputs();
        end
        idle_inputs(); load_pc = 1'b1; step(); idle_inputs();
        checks++; if (pc !== 5'd3) begin errors++; $display("FAIL halt_pc got %0d exp 3", pc); end
        checks++; if (ac !== 8'h22) begin errors++; $display("FAIL halt_ac got %h exp 22", ac); end
        checks++; if (opcode !== LDA) begin errors++; $display("FAIL halt_ir got %0d exp %0d", opcode, LDA); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky got %b exp 1", halted); end
        idle_inputs(); rst = 1'b1; step(); idle_inputs();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear got %b exp 0", halted); end
        state = STORE; mem_wr = 1'b1; #1;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL we_after_rst got %b exp 1", mem_we); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        test_reset();
        test_fetch_alu();
        test_xor_zero();
        test_ir_ac_same_edge();
        test_jmp_wrap();
        test_store();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cpu_datapath
